// File: rtl/fsm_symbol_feeder.sv
// -----------------------------------------------------------------------------
// fsm_symbol_feeder
// Upstream feeder for a table-driven state machine. A 1-bit serial stream is
// packed MSB-first into 4-bit symbols, which are queued in a small FIFO. A run
// (START) presets the machine to SEED, replays the queued symbols one per clock
// with ENABLE high, then captures the machine's final state into RESULT and
// pulses DONE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sdi        serial symbol bit, MSB first
//   sdi_valid  qualifies sdi for one clock
//   seed       state to preset the machine with before a run
//   start      run request, only honoured in IDLE with a non-empty FIFO
//   y          current machine state
//   x          symbol to the machine (registered)
//   enable     machine step enable (registered); 0 makes the machine load preset_y
//   preset_y   preset state to the machine (registered)
//   full       FIFO holds DEPTH symbols
//   empty      FIFO holds no symbols
//   busy       high while in RUN or CAPTURE (registered)
//   done       one-cycle pulse when result is updated (registered)
//   result     final machine state of the last run (registered)
//   overflow   sticky: a completed symbol was dropped on a full FIFO
// -----------------------------------------------------------------------------
module fsm_symbol_feeder #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  input  logic       sdi_valid,
  input  logic [3:0] seed,
  input  logic       start,
  input  logic [3:0] y,
  output logic [3:0] x,
  output logic       enable,
  output logic [3:0] preset_y,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   remain_q, remain_d;
  logic [3:0]      shift_q, shift_d;
  logic [1:0]      bitcnt_q, bitcnt_d;
  logic [3:0]      x_q, x_d;
  logic            enable_q, enable_d;
  logic [3:0]      preset_y_q, preset_y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      result_q, result_d;
  logic            overflow_q, overflow_d;

  logic            full_s;
  logic            empty_s;
  logic            sym_complete_s;
  logic [3:0]      sym_s;
  logic            start_ok_s;
  logic            pop_s;
  logic            push_s;
  logic [3:0]      head_s;

  assign full_s         = (occ_q == CW'(DEPTH));
  assign empty_s        = (occ_q == CW'(0));
  // The 4th valid bit completes a symbol; it is pushed at that same edge.
  assign sym_complete_s = sdi_valid && (bitcnt_q == 2'd3);
  assign sym_s          = {shift_q[2:0], sdi};
  assign start_ok_s     = (state_q == ST_IDLE) && start && !empty_s;
  // REMAIN never exceeds occupancy, so a RUN pop always finds a symbol.
  assign pop_s          = start_ok_s || ((state_q == ST_RUN) && (remain_q != CW'(0)));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s         = sym_complete_s && (!full_s || pop_s);
  assign head_s         = mem_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (remain_q == CW'(0)) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values: deserialiser, FIFO bookkeeping, run control.
  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    remain_d   = remain_q;
    x_d        = 4'h0;
    enable_d   = 1'b0;
    preset_y_d = preset_y_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = (state_d != ST_IDLE);

    if (sdi_valid) begin
      shift_d  = sym_s;
      bitcnt_d = bitcnt_q + 2'd1;
    end else begin
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    // Accepting a run clears the sticky flag; a dropped symbol sets it.
    if (start_ok_s) begin
      overflow_d = 1'b0;
    end else if (sym_complete_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          // Snapshot the occupancy now; symbols pushed later wait for the next run.
          x_d        = head_s;
          enable_d   = 1'b1;
          remain_d   = occ_q - CW'(1);
          preset_y_d = preset_y_q;
        end else begin
          x_d        = 4'h0;
          enable_d   = 1'b0;
          remain_d   = remain_q;
          preset_y_d = seed;
        end
      end
      ST_RUN: begin
        if (remain_q != CW'(0)) begin
          x_d      = head_s;
          enable_d = 1'b1;
          remain_d = remain_q - CW'(1);
        end else begin
          x_d      = 4'h0;
          enable_d = 1'b0;
          remain_d = remain_q;
        end
      end
      ST_CAPTURE: begin
        // The machine reloads preset_y at this same edge since enable is low.
        result_d = y;
        done_d   = 1'b1;
      end
      default: begin
        x_d      = 4'h0;
        enable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      remain_q   <= '0;
      shift_q    <= 4'h0;
      bitcnt_q   <= 2'd0;
      x_q        <= 4'h0;
      enable_q   <= 1'b0;
      preset_y_q <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 4'h0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      remain_q   <= remain_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      x_q        <= x_d;
      enable_q   <= enable_d;
      preset_y_q <= preset_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= sym_s;
    end
  end

  assign x        = x_q;
  assign enable   = enable_q;
  assign preset_y = preset_y_q;
  assign full     = full_s;
  assign empty    = empty_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fsm_symbol_feeder.sv
// -----------------------------------------------------------------------------
// tb_fsm_symbol_feeder
// Directed bench for fsm_symbol_feeder with a behavioural machine stub
// (y <= enable ? y ^ x : preset_y). A table of runs is replayed in a loop,
// followed by hand-written sequences for overflow, ignored starts, pushes
// during a run, simultaneous push/pop on a full FIFO and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_fsm_symbol_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdi = 1'b0;
  logic       sdi_valid = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       start = 1'b0;
  logic [3:0] y_m;
  logic [3:0] x;
  logic       enable;
  logic [3:0] preset_y;
  logic       full;
  logic       empty;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          n;
    logic [31:0] syms;     // symbol k in bits [4k+3:4k]
    logic [3:0]  seed;
    logic [3:0]  exp_res;
  } vec_t;

  vec_t vecs [4];

  fsm_symbol_feeder #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .seed      (seed),
    .start     (start),
    .y         (y_m),
    .x         (x),
    .enable    (enable),
    .preset_y  (preset_y),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Machine stub driven by the feeder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_m <= 4'h0;
    else        y_m <= enable ? (y_m ^ x) : preset_y;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [17:0] outs();
    return {x, enable, preset_y, full, empty, busy, done, result, overflow};
  endfunction

  // Shift bits s[hi]..s[lo] one per clock; called and returns at a falling edge.
  task automatic send_bits(input logic [3:0] s, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      sdi       = s[b];
      sdi_valid = 1'b1;
      @(negedge clk);
    end
    sdi_valid = 1'b0;
    sdi       = 1'b0;
  endtask

  task automatic push_list(input logic [31:0] syms, input int n);
    for (int k = 0; k < n; k++) send_bits(syms[4*k +: 4], 3, 0);
  endtask

  // One run from a falling edge: expects the n listed symbols in order.
  task automatic do_run(input logic [31:0] syms, input int n, input logic [3:0] exp,
                        input bit extra_start);
    check("preset_y_idle", 32'(preset_y), 32'(seed));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("overflow_after_start", 32'(overflow), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check("run_x", 32'(x), 32'(syms[4*i +: 4]));
      check("run_enable", 32'(enable), 32'd1);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done_low", 32'(done), 32'd0);
      start = extra_start && (i == 0);
    end
    @(negedge clk);
    start = 1'b0;
    check("end_enable", 32'(enable), 32'd0);
    check("end_x", 32'(x), 32'd0);
    check("capture_busy", 32'(busy), 32'd1);
    check("capture_done_low", 32'(done), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("result", 32'(result), 32'(exp));
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'(exp));
    check("idle_after_run", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{3, 32'h0000_0421, 4'h3, 4'h4};
    vecs[1] = '{1, 32'h0000_000A, 4'h5, 4'hF};
    vecs[2] = '{5, 32'h0003_81FF, 4'h0, 4'hA};
    vecs[3] = '{2, 32'h0000_006C, 4'h9, 4'h3};

    // Reset asserted mid-cycle: outputs clear at once.
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 32'(outs()), 32'h0000_0080);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven runs.
    for (int v = 0; v < 4; v++) begin
      seed = vecs[v].seed;
      push_list(vecs[v].syms, vecs[v].n);
      check("empty_before_run", 32'(empty), 32'd0);
      do_run(vecs[v].syms, vecs[v].n, vecs[v].exp_res, 1'b0);
      check("empty_after_run", 32'(empty), 32'd1);
    end

    // Nine pushes into DEPTH=8: last one is dropped.
    seed = 4'h0;
    push_list(32'h8765_4321, 8);
    check("full_at_8", 32'(full), 32'd1);
    check("no_overflow_at_8", 32'(overflow), 32'd0);
    send_bits(4'h9, 3, 0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("full_after_9", 32'(full), 32'd1);
    do_run(32'h8765_4321, 8, 4'h8, 1'b0);
    check("ninth_lost", 32'(empty), 32'd1);

    // START with an empty FIFO is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("empty_start_enable", 32'(enable), 32'd0);
      check("empty_start_busy", 32'(busy), 32'd0);
      check("empty_start_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    // START during RUN is ignored.
    seed = 4'h4;
    push_list(32'h0000_0B72, 3);
    do_run(32'h0000_0B72, 3, 4'hA, 1'b1);
    check("restart_ignored_empty", 32'(empty), 32'd1);

    // Two symbols pushed during a run of three stay for the next run.
    seed = 4'h1;
    push_list(32'h0000_0653, 3);
    send_bits(4'h7, 3, 1);
    fork
      do_run(32'h0000_0653, 3, 4'h1, 1'b0);
      begin
        @(negedge clk);
        send_bits(4'h7, 0, 0);
        send_bits(4'h9, 3, 0);
      end
    join
    check("left_after_run", 32'(empty), 32'd0);
    check("left_not_full", 32'(full), 32'd0);
    do_run(32'h0000_0097, 2, 4'hF, 1'b0);

    // Full FIFO: push and pop on the same edge do not overflow.
    seed = 4'h6;
    push_list(32'h89AB_CDEF, 8);
    check("full_before_pushpop", 32'(full), 32'd1);
    send_bits(4'h5, 3, 1);
    fork
      do_run(32'h89AB_CDEF, 8, 4'h6, 1'b0);
      begin
        send_bits(4'h5, 0, 0);
        check("full_after_pushpop", 32'(full), 32'd1);
        check("no_overflow_pushpop", 32'(overflow), 32'd0);
      end
    join
    check("pushpop_sym_kept", 32'(empty), 32'd0);
    do_run(32'h0000_0005, 1, 4'h3, 1'b0);

    // Reset during a run after two of five steps.
    seed = 4'h2;
    push_list(32'h0005_4321, 5);
    send_bits(4'hC, 3, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs", 32'(outs()), 32'h0000_0080);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_reset", 32'(done), 32'd0);
      check("result_zero_after_reset", 32'(result), 32'd0);
    end
    check("fifo_empty_after_reset", 32'(empty), 32'd1);
    send_bits(4'hA, 3, 0);
    check("fresh_symbol_pushed", 32'(empty), 32'd0);
    do_run(32'h0000_000A, 1, 4'h8, 1'b0);
    check("fresh_symbol_only", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
